// File: rtl/mac_accumulator_if.sv
// Valid/ready bundle between the multiplier stream, the accumulator and its result consumer.
// The master modport is the stimulus/consumer side; the slave modport is the accumulator.
interface mac_accumulator_if #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned CNT_W  = 8
) ();
   logic              start;
   logic [CNT_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              overflow;
   logic              busy;

   modport master (
      output start, len, in_valid, product, out_ready,
      input  in_ready, out_valid, acc_out, overflow, busy
   );

   modport slave (
      input  start, len, in_valid, product, out_ready,
      output in_ready, out_valid, acc_out, overflow, busy
   );
endinterface

// File: rtl/mac_accumulator.sv
// Accumulate stage of the MAC datapath: sums a programmed number of unsigned products
// into a wider register and presents the total on a valid/ready port with a sticky overflow.
module mac_accumulator #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned CNT_W  = 8
) (
   input logic              clk,
   input logic              rst,
   mac_accumulator_if.slave bus
);
   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             overflow_q, overflow_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic             beat_c;
   logic [SUM_W-1:0] sum_c;

   // in_ready_q is only ever high in ACCUM, so it alone qualifies a beat
   assign beat_c = bus.in_valid & in_ready_q;
   assign sum_c  = {1'b0, acc_q} + SUM_W'(bus.product);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : ACCUM;
         ACCUM:   if (beat_c && (remaining_q == CNT_W'(1))) state_d = DONE;
         DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values; handshake outputs follow the next state so they stay registered
   always_comb begin
      acc_d       = acc_q;
      overflow_d  = overflow_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d       = '0;
               overflow_d  = 1'b0;
               remaining_d = bus.len;
            end
         end
         ACCUM: begin
            if (beat_c) begin
               acc_d       = sum_c[ACC_W-1:0];
               overflow_d  = overflow_q | sum_c[ACC_W];
               remaining_d = remaining_q - CNT_W'(1);
            end
         end
         default: ;
      endcase
      in_ready_d  = (state_d == ACCUM);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         overflow_q  <= 1'b0;
         remaining_q <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         overflow_q  <= overflow_d;
         remaining_q <= remaining_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.acc_out   = acc_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a 24-bit and a 20-bit instance run the same stream in
// lockstep, and expected sums are queued as each run is launched and popped when out_valid rises.
module tb_mac_accumulator;
   logic clk = 1'b0;
   logic rst;
   logic start, in_valid, out_ready;
   logic [7:0]  len;
   logic [15:0] product;

   always #5 clk = ~clk;

   mac_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus_a ();
   mac_accumulator_if #(.PROD_W(16), .ACC_W(20), .CNT_W(8)) bus_b ();

   assign bus_a.start = start;     assign bus_b.start = start;
   assign bus_a.len = len;         assign bus_b.len = len;
   assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
   assign bus_a.product = product; assign bus_b.product = product;
   assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

   mac_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   mac_accumulator #(.PROD_W(16), .ACC_W(20), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   typedef struct packed {
      logic        ovf;
      logic [23:0] acc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks   = 0;
   int   failures = 0;
   int   beats_a  = 0;

   always @(posedge clk) if (bus_a.in_valid && bus_a.in_ready) beats_a <= beats_a + 1;

   // Reference: the true sum reduced mod 2^w; any wrap means the total reached 2^w
   function automatic exp_t model(input longint tot, input int w);
      exp_t   e;
      longint m;
      m     = longint'(1) << w;
      e.acc = 24'(tot % m);
      e.ovf = (tot >= m);
      return e;
   endfunction

   task automatic push_expected(input longint tot);
      q_a.push_back(model(tot, 24));
      q_b.push_back(model(tot, 20));
   endtask

   task automatic do_start(input logic [7:0] n);
      start = 1'b1;
      len   = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input logic [15:0] p, input int gap);
      int n;
      repeat (gap) begin
         in_valid = 1'b0;
         product  = 16'hFFFF;
         @(negedge clk);
      end
      in_valid = 1'b1;
      product  = p;
      n = 0;
      while (!bus_a.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus_a.in_ready) begin
         checks++;
         failures++;
         $display("FAIL feed_timeout in_ready=%b required 1", bus_a.in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic timed_out);
      int n;
      n = 0;
      while (!(bus_a.out_valid && bus_b.out_valid) && n < 600) begin
         @(negedge clk);
         n++;
      end
      timed_out = !(bus_a.out_valid && bus_b.out_valid);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus_a.in_ready, bus_a.out_valid, bus_a.busy, bus_a.overflow, bus_a.acc_out} !== 28'd0) begin
         failures++;
         $display("FAIL reset_a rdy=%b vld=%b busy=%b ovf=%b acc=%0d required all 0",
                  bus_a.in_ready, bus_a.out_valid, bus_a.busy, bus_a.overflow, bus_a.acc_out);
      end
      checks++;
      if ({bus_b.in_ready, bus_b.out_valid, bus_b.busy, bus_b.overflow, bus_b.acc_out} !== 24'd0) begin
         failures++;
         $display("FAIL reset_b rdy=%b vld=%b busy=%b ovf=%b acc=%0d required all 0",
                  bus_b.in_ready, bus_b.out_valid, bus_b.busy, bus_b.overflow, bus_b.acc_out);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t ea, eb;
      logic to;
      do_start(8'd4);
      push_expected(1000);
      feed(16'd100, 0); feed(16'd200, 0); feed(16'd300, 0); feed(16'd400, 0);
      checks++;
      if (bus_a.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_latency out_valid=%b required 1 the cycle after the last beat", bus_a.out_valid);
      end
      checks++;
      if (bus_a.busy !== 1'b1 || bus_a.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_flags busy=%b in_ready=%b required 1/0", bus_a.busy, bus_a.in_ready);
      end
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_a.overflow !== ea.ovf) begin
         failures++;
         $display("FAIL b2b_a acc=%0d ovf=%b required acc=%0d ovf=%b", bus_a.acc_out, bus_a.overflow, ea.acc, ea.ovf);
      end
      checks++;
      if (to || bus_b.acc_out !== eb.acc[19:0] || bus_b.overflow !== eb.ovf) begin
         failures++;
         $display("FAIL b2b_b acc=%0d ovf=%b required acc=%0d ovf=%b", bus_b.acc_out, bus_b.overflow, eb.acc[19:0], eb.ovf);
      end
      take();
   endtask

   task automatic test_gaps_backpressure();
      exp_t ea, eb;
      logic to;
      do_start(8'd4);
      push_expected(1000);
      feed(16'd100, int'($urandom_range(1, 3)));
      feed(16'd200, int'($urandom_range(1, 3)));
      feed(16'd300, int'($urandom_range(1, 3)));
      feed(16'd400, int'($urandom_range(1, 3)));
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_a.overflow !== ea.ovf) begin
         failures++;
         $display("FAIL gaps_a acc=%0d ovf=%b required acc=%0d ovf=%b", bus_a.acc_out, bus_a.overflow, ea.acc, ea.ovf);
      end
      checks++;
      if (to || bus_b.acc_out !== eb.acc[19:0] || bus_b.overflow !== eb.ovf) begin
         failures++;
         $display("FAIL gaps_b acc=%0d ovf=%b required acc=%0d ovf=%b", bus_b.acc_out, bus_b.overflow, eb.acc[19:0], eb.ovf);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== ea.acc) begin
            failures++;
            $display("FAIL hold_cycle%0d out_valid=%b acc=%0d required 1 and %0d", i, bus_a.out_valid, bus_a.acc_out, ea.acc);
         end
      end
      take();
      checks++;
      if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
         failures++;
         $display("FAIL release out_valid=%b busy=%b required 0/0 after handshake", bus_a.out_valid, bus_a.busy);
      end
   endtask

   task automatic test_overflow_wrap();
      exp_t ea, eb;
      logic to;
      do_start(8'd17);
      push_expected(longint'(17) * 65025);
      for (int i = 0; i < 17; i++) feed(16'd65025, 0);
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_b.acc_out !== eb.acc[19:0] || bus_b.overflow !== eb.ovf) begin
         failures++;
         $display("FAIL wrap_b acc=%0d ovf=%b required acc=%0d ovf=%b", bus_b.acc_out, bus_b.overflow, eb.acc[19:0], eb.ovf);
      end
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_a.overflow !== ea.ovf) begin
         failures++;
         $display("FAIL wrap_a acc=%0d ovf=%b required acc=%0d ovf=%b", bus_a.acc_out, bus_a.overflow, ea.acc, ea.ovf);
      end
      take();
      do_start(8'd1);
      push_expected(5);
      feed(16'd5, 0);
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_b.acc_out !== eb.acc[19:0] || bus_b.overflow !== eb.ovf) begin
         failures++;
         $display("FAIL sticky_clear_b acc=%0d ovf=%b required acc=%0d ovf=%b", bus_b.acc_out, bus_b.overflow, eb.acc[19:0], eb.ovf);
      end
      take();
   endtask

   task automatic test_len_bounds();
      exp_t ea, eb;
      logic to;
      do_start(8'd0);
      push_expected(0);
      checks++;
      if (bus_a.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL len0_latency out_valid=%b required 1 the cycle after start", bus_a.out_valid);
      end
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_a.overflow !== ea.ovf || bus_b.acc_out !== eb.acc[19:0]) begin
         failures++;
         $display("FAIL len0 acc_a=%0d ovf_a=%b acc_b=%0d required 0/0/0", bus_a.acc_out, bus_a.overflow, bus_b.acc_out);
      end
      take();
      do_start(8'd255);
      push_expected(longint'(255) * 65025);
      for (int i = 0; i < 255; i++) feed(16'd65025, 0);
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_a.overflow !== ea.ovf) begin
         failures++;
         $display("FAIL len255_a acc=%0d ovf=%b required acc=%0d ovf=%b", bus_a.acc_out, bus_a.overflow, ea.acc, ea.ovf);
      end
      checks++;
      if (to || bus_b.acc_out !== eb.acc[19:0] || bus_b.overflow !== eb.ovf) begin
         failures++;
         $display("FAIL len255_b acc=%0d ovf=%b required acc=%0d ovf=%b", bus_b.acc_out, bus_b.overflow, eb.acc[19:0], eb.ovf);
      end
      take();
   endtask

   task automatic test_reset_mid_run();
      exp_t ea, eb;
      logic to;
      do_start(8'd4);
      feed(16'd11, 0);
      feed(16'd22, 0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_a.in_ready, bus_a.out_valid, bus_a.busy, bus_a.overflow, bus_a.acc_out} !== 28'd0) begin
         failures++;
         $display("FAIL midrst_a rdy=%b vld=%b busy=%b ovf=%b acc=%0d required all 0",
                  bus_a.in_ready, bus_a.out_valid, bus_a.busy, bus_a.overflow, bus_a.acc_out);
      end
      rst = 1'b0;
      @(negedge clk);
      do_start(8'd1);
      push_expected(7);
      feed(16'd7, 0);
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_a.overflow !== ea.ovf) begin
         failures++;
         $display("FAIL after_rst_a acc=%0d ovf=%b required acc=%0d ovf=%b", bus_a.acc_out, bus_a.overflow, ea.acc, ea.ovf);
      end
      take();
   endtask

   task automatic test_ignored_inputs();
      exp_t ea, eb;
      logic to;
      int   b0;
      b0       = beats_a;
      in_valid = 1'b1;
      product  = 16'd99;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (beats_a !== b0) begin
         failures++;
         $display("FAIL idle_beats accepted=%0d required 0", beats_a - b0);
      end
      b0 = beats_a;
      do_start(8'd2);
      push_expected(7);
      feed(16'd3, 0);
      start = 1'b1;
      len   = 8'd9;
      @(negedge clk);
      start = 1'b0;
      feed(16'd4, 1);
      wait_out(to);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checks++;
      if (to || bus_a.acc_out !== ea.acc || bus_b.acc_out !== eb.acc[19:0]) begin
         failures++;
         $display("FAIL ignore_acc acc_a=%0d acc_b=%0d required %0d", bus_a.acc_out, bus_b.acc_out, ea.acc);
      end
      checks++;
      if (beats_a - b0 !== 2) begin
         failures++;
         $display("FAIL ignore_beats accepted=%0d required 2", beats_a - b0);
      end
      // start coincident with the DONE handshake, plus a stray product, must all be dropped
      start     = 1'b1;
      len       = 8'd3;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      product   = 16'd99;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL done_start busy=%b out_valid=%b in_ready=%b required 0/0/0",
                  bus_a.busy, bus_a.out_valid, bus_a.in_ready);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = 8'd0;
      in_valid  = 1'b0;
      product   = 16'd0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_gaps_backpressure();
      test_overflow_wrap();
      test_len_bounds();
      test_reset_mid_run();
      test_ignored_inputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end
endmodule
